tb_sim_ctrl: RTL and testbench

//  Parametrised end-of-simulation controller for the CHERIoT bench.
//  - Monitors NUM_SRC stop-request sources (UART, tohost, watchdog, ...) and a cycle-count timeout.
//  - Runs the end_sim req/ack drain handshake with the DUT top.
//  - Counts the post-drain settle cycles, then raises finish_o.
//  - Generalises the fixed single-source stop / fixed-timeout sequencing into a reusable clocked block.
//  - The bench calls $finish on finish_o.

---
 rtl/tb_sim_ctrl_pkg.sv | 33 +++
 rtl/tb_prio_enc.sv | 33 +++
 rtl/tb_sim_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tb_sim_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_sim_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tb_sim_ctrl_pkg
// Shared types and sizing helpers for the end-of-simulation controller.
//   sim_state_e   : controller phases IDLE -> RUN -> DRAIN -> POST -> DONE
//   stop_reason_e : why the run ended (NONE / STOP / TIMEOUT)
//   cntWidth()    : bits needed to hold the values 0..count-1, never below 1
// ---------------------------------------------------------------------------
package tb_sim_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } sim_state_e;

  typedef enum logic [1:0] {
    REASON_NONE    = 2'd0,
    REASON_STOP    = 2'd1,
    REASON_TIMEOUT = 2'd2
  } stop_reason_e;

  // Width of a counter or index that must represent 0..count-1.
  // Degenerate counts (0, 1, 2) still get one bit so no vector collapses.
  function automatic int cntWidth(input int count);
    if (count <= 2) begin
      return 1;
    end
    return $clog2(count);
  endfunction

endpackage

// File: rtl/tb_prio_enc.sv
// ---------------------------------------------------------------------------
// tb_prio_enc
// Combinational lowest-set-bit priority encoder used to pick which stop
// source ended the run.
//   req_i   [N-1:0] : request vector, bit i = source i
//   idx_o   [W-1:0] : index of the lowest set bit (0 when none set)
//   valid_o         : at least one request bit is set
// ---------------------------------------------------------------------------
module tb_prio_enc
  import tb_sim_ctrl_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = cntWidth(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top bit down so that the last hit, which overwrites any
  // earlier one, is the lowest set index.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tb_sim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sim_ctrl
// End-of-simulation controller for the CHERIoT bench. Watches NUM_SRC stop
// requests plus an optional run-length timeout, performs the end_sim
// req/ack drain handshake with the DUT top, waits POST_CYCLES settle
// cycles and then raises finish_o so the bench can call $finish.
//   clk_i, rst_i            : bench clock, async active-high reset
//   start_i                 : one-cycle pulse starting a run (IDLE only)
//   timeout_i [CNT_W-1:0]   : run-cycle limit, 0 disables; sampled on start
//   stop_req_i [NUM_SRC-1:0]: level stop requests, bit i = source i
//   end_sim_ack_i           : DUT top reports drain complete
//   end_sim_req_o           : drain request to DUT top (DRAIN/POST/DONE)
//   finish_o                : run complete
//   reason_o [1:0]          : stop_reason_e of the finished run
//   stop_src_o [SRC_W-1:0]  : index of the stop source that ended the run
//   ack_tmo_o               : drain ended by DRAIN_MAX rather than by ack
//   cycle_cnt_o [CNT_W-1:0] : number of RUN cycles, saturating
// ---------------------------------------------------------------------------
module tb_sim_ctrl
  import tb_sim_ctrl_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int CNT_W       = 32,
  parameter  int DRAIN_MAX   = 10000,
  parameter  int POST_CYCLES = 10,
  localparam int SRC_W       = cntWidth(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   timeout_i,
  input  logic [NUM_SRC-1:0] stop_req_i,
  input  logic               end_sim_ack_i,
  output logic               end_sim_req_o,
  output logic               finish_o,
  output logic [1:0]         reason_o,
  output logic [SRC_W-1:0]   stop_src_o,
  output logic               ack_tmo_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);

  // The drain and post phases never overlap, so they share one counter
  // sized for whichever phase is longer.
  localparam int DRAIN_W = cntWidth(DRAIN_MAX);
  localparam int POST_W  = cntWidth(POST_CYCLES);
  localparam int PH_W    = (DRAIN_W > POST_W) ? DRAIN_W : POST_W;

  // Last counter value of each phase; a zero-length POST still spends one
  // cycle in POST so the state sequence stays the same for every setting.
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'((DRAIN_MAX > 0) ? DRAIN_MAX - 1 : 0);
  localparam logic [PH_W-1:0] POST_LAST  = PH_W'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);

  sim_state_e   state_q, state_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  stop_reason_e reason_q, reason_d;
  logic [SRC_W-1:0] stopSrc_q, stopSrc_d;
  logic         ackTmo_q, ackTmo_d;
  logic         endSimReq_q, endSimReq_d;
  logic [PH_W-1:0] phaseCnt_q, phaseCnt_d;

  logic [SRC_W-1:0] stopIdx;
  logic             stopValid;
  logic             timeoutHit;

  tb_prio_enc #(
    .N (NUM_SRC)
  ) u_prio_enc (
    .req_i   (stop_req_i),
    .idx_o   (stopIdx),
    .valid_o (stopValid)
  );

  // Timeout fires on the last permitted RUN cycle, judged on the count
  // before this cycle's increment, so a limit of T yields exactly T RUN
  // cycles. A latched limit of zero means the run only ends on a stop.
  assign timeoutHit = (timeout_q != '0) && (cycleCnt_q == timeout_q - CNT_W'(1));

  // Next-state and next-register logic for the whole controller. Every
  // register holds by default; each state only overrides what it changes.
  // Stop requests beat the timeout when both land on the same cycle.
  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    cycleCnt_d  = cycleCnt_q;
    reason_d    = reason_q;
    stopSrc_d   = stopSrc_q;
    ackTmo_d    = ackTmo_q;
    endSimReq_d = endSimReq_q;
    phaseCnt_d  = phaseCnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          timeout_d   = timeout_i;
          cycleCnt_d  = '0;
          reason_d    = REASON_NONE;
          stopSrc_d   = '0;
          ackTmo_d    = 1'b0;
          endSimReq_d = 1'b0;
          phaseCnt_d  = '0;
        end
      end

      S_RUN: begin
        if (cycleCnt_q != '1) begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
        if (stopValid) begin
          state_d     = S_DRAIN;
          reason_d    = REASON_STOP;
          stopSrc_d   = stopIdx;
          endSimReq_d = 1'b1;
          phaseCnt_d  = '0;
        end else if (timeoutHit) begin
          state_d     = S_DRAIN;
          reason_d    = REASON_TIMEOUT;
          endSimReq_d = 1'b1;
          phaseCnt_d  = '0;
        end
      end

      S_DRAIN: begin
        if (end_sim_ack_i) begin
          state_d    = S_POST;
          ackTmo_d   = 1'b0;
          phaseCnt_d = '0;
        end else if (phaseCnt_q == DRAIN_LAST) begin
          state_d    = S_POST;
          ackTmo_d   = 1'b1;
          phaseCnt_d = '0;
        end else begin
          phaseCnt_d = phaseCnt_q + PH_W'(1);
        end
      end

      S_POST: begin
        if (phaseCnt_q == POST_LAST) begin
          state_d = S_DONE;
        end else begin
          phaseCnt_d = phaseCnt_q + PH_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers. Reset clears everything at once so an
  // aborted run can never leak a finish or a stale reason.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      timeout_q   <= '0;
      cycleCnt_q  <= '0;
      reason_q    <= REASON_NONE;
      stopSrc_q   <= '0;
      ackTmo_q    <= 1'b0;
      endSimReq_q <= 1'b0;
      phaseCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      cycleCnt_q  <= cycleCnt_d;
      reason_q    <= reason_d;
      stopSrc_q   <= stopSrc_d;
      ackTmo_q    <= ackTmo_d;
      endSimReq_q <= endSimReq_d;
      phaseCnt_q  <= phaseCnt_d;
    end
  end

  assign end_sim_req_o = endSimReq_q;
  assign finish_o      = (state_q == S_DONE);
  assign reason_o      = reason_q;
  assign stop_src_o    = stopSrc_q;
  assign ack_tmo_o     = ackTmo_q;
  assign cycle_cnt_o   = cycleCnt_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tb_sim_ctrl
// Directed bench for tb_sim_ctrl. Instance A (CNT_W=32, DRAIN_MAX=20)
// carries the run/stop/drain/reset scenarios; instance B (CNT_W=8) shows
// counter saturation. Each started run pushes its expected outcome into a
// queue which is popped when finish_o rises.
// ---------------------------------------------------------------------------
module tb_tb_sim_ctrl;
  import tb_sim_ctrl_pkg::*;

  typedef struct {
    logic [1:0]  reason;
    logic [1:0]  src;
    logic        ackTmo;
    logic [31:0] cnt;
  } expRun_t;

  logic        clk;
  logic        rst;

  logic        startA;
  logic [31:0] timeoutA;
  logic [3:0]  stopA;
  logic        ackA;
  logic        reqA;
  logic        finishA;
  logic [1:0]  reasonA;
  logic [1:0]  srcA;
  logic        ackTmoA;
  logic [31:0] cntA;

  logic        startB;
  logic [7:0]  timeoutB;
  logic [3:0]  stopB;
  logic        ackB;
  logic        reqB;
  logic        finishB;
  logic [1:0]  reasonB;
  logic [1:0]  srcB;
  logic        ackTmoB;
  logic [7:0]  cntB;

  expRun_t sbQ[$];
  int      total = 0;
  int      bad   = 0;

  tb_sim_ctrl #(
    .NUM_SRC     (4),
    .CNT_W       (32),
    .DRAIN_MAX   (20),
    .POST_CYCLES (10)
  ) dutA (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (startA),
    .timeout_i     (timeoutA),
    .stop_req_i    (stopA),
    .end_sim_ack_i (ackA),
    .end_sim_req_o (reqA),
    .finish_o      (finishA),
    .reason_o      (reasonA),
    .stop_src_o    (srcA),
    .ack_tmo_o     (ackTmoA),
    .cycle_cnt_o   (cntA)
  );

  tb_sim_ctrl #(
    .NUM_SRC     (4),
    .CNT_W       (8),
    .DRAIN_MAX   (20),
    .POST_CYCLES (10)
  ) dutB (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (startB),
    .timeout_i     (timeoutB),
    .stop_req_i    (stopB),
    .end_sim_ack_i (ackB),
    .end_sim_req_o (reqB),
    .finish_o      (finishB),
    .reason_o      (reasonB),
    .stop_src_o    (srcB),
    .ack_tmo_o     (ackTmoB),
    .cycle_cnt_o   (cntB)
  );

  // Free-running 10-unit bench clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge, where inputs are
  // driven and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts, asserts and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Pulse start on instance A with the given limit, optionally queueing
  // the outcome the run is expected to finish with. The limit input is
  // scrambled afterwards so only the latched copy can matter.
  task automatic applyStimulus(input logic [31:0] tmo, input expRun_t exp,
                               input bit expectFinish);
    if (expectFinish) sbQ.push_back(exp);
    startA   = 1'b1;
    timeoutA = tmo;
    tick();
    startA   = 1'b0;
    timeoutA = 32'hDEAD_BEEF;
  endtask

  // One-cycle ack pulse from the pretend DUT top.
  task automatic pulseAck();
    ackA = 1'b1;
    tick();
    ackA = 1'b0;
  endtask

  // Called right after POST entry: wait (bounded) for finish_o, check the
  // settle length, then pop the expected outcome and compare it.
  task automatic waitFinish(input string tag, input int expCycles);
    int      n;
    expRun_t exp;
    n = 0;
    while (finishA !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_finish"}, 64'(finishA), 64'd1);
    checkOutput({tag, "_postCycles"}, 64'(n), 64'(expCycles));
    checkOutput({tag, "_sbDepth"}, 64'(sbQ.size()), 64'd1);
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      checkOutput({tag, "_reason"}, 64'(reasonA), 64'(exp.reason));
      checkOutput({tag, "_src"},    64'(srcA),    64'(exp.src));
      checkOutput({tag, "_ackTmo"}, 64'(ackTmoA), 64'(exp.ackTmo));
      checkOutput({tag, "_cnt"},    64'(cntA),    64'(exp.cnt));
      checkOutput({tag, "_req"},    64'(reqA),    64'd1);
    end
  endtask

  // Assert reset between edges and confirm every output clears at once.
  task automatic resetPulse(input string tag);
    rst = 1'b1;
    #1;
    checkOutput(tag, 64'({reqA, finishA, reasonA, srcA, ackTmoA, cntA}), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    expRun_t none;
    none = '{REASON_NONE, 2'd0, 1'b0, 32'd0};

    rst = 1'b1;
    startA = 1'b0; timeoutA = '0; stopA = '0; ackA = 1'b0;
    startB = 1'b0; timeoutB = '0; stopB = '0; ackB = 1'b0;
    #1;
    checkOutput("resetA", 64'({reqA, finishA, reasonA, srcA, ackTmoA, cntA}), 64'd0);
    checkOutput("resetB", 64'({reqB, finishB, reasonB, srcB, ackTmoB, cntB}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] timeout of 100 with no stops");
    applyStimulus(32'd100, '{REASON_TIMEOUT, 2'd0, 1'b0, 32'd100}, 1'b1);
    checkOutput("s1_cnt0", 64'(cntA), 64'd0);
    repeat (99) tick();
    checkOutput("s1_cnt99", 64'(cntA), 64'd99);
    checkOutput("s1_reqLowInRun", 64'(reqA), 64'd0);
    tick();
    checkOutput("s1_reqRise", 64'(reqA), 64'd1);
    pulseAck();
    waitFinish("s1", 10);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    tick();
    checkOutput("s1_doneHold", 64'({finishA, cntA}), {31'd0, 1'b1, 32'd100});
    resetPulse("s1_rst");

    $display("[TB] stop source 2 after 37 run cycles, ack 5 cycles later");
    applyStimulus(32'd0, '{REASON_STOP, 2'd2, 1'b0, 32'd38}, 1'b1);
    repeat (37) tick();
    stopA = 4'b0100;
    tick();
    stopA = 4'b0001;
    checkOutput("s2_req", 64'(reqA), 64'd1);
    repeat (4) tick();
    stopA = 4'b0000;
    pulseAck();
    waitFinish("s2", 10);
    resetPulse("s2_rst");

    $display("[TB] stop and timeout on the same cycle");
    applyStimulus(32'd50, '{REASON_STOP, 2'd1, 1'b0, 32'd50}, 1'b1);
    repeat (49) tick();
    stopA = 4'b1010;
    tick();
    stopA = 4'b0000;
    pulseAck();
    waitFinish("s3", 10);
    resetPulse("s3_rst");

    $display("[TB] drain never acknowledged");
    applyStimulus(32'd5, '{REASON_TIMEOUT, 2'd0, 1'b1, 32'd5}, 1'b1);
    repeat (5) tick();
    checkOutput("s4_reqRise", 64'(reqA), 64'd1);
    repeat (19) tick();
    checkOutput("s4_ackTmoPending", 64'({reqA, ackTmoA}), 64'b10);
    tick();
    checkOutput("s4_ackTmo", 64'(ackTmoA), 64'd1);
    waitFinish("s4", 10);
    resetPulse("s4_rst");

    $display("[TB] ack on the final drain cycle");
    applyStimulus(32'd5, '{REASON_TIMEOUT, 2'd0, 1'b0, 32'd5}, 1'b1);
    repeat (24) tick();
    pulseAck();
    checkOutput("s4b_ackTmo", 64'(ackTmoA), 64'd0);
    waitFinish("s4b", 10);
    resetPulse("s4b_rst");

    $display("[TB] timeout disabled, stop after 1000 cycles");
    applyStimulus(32'd0, '{REASON_STOP, 2'd0, 1'b0, 32'd1001}, 1'b1);
    repeat (1000) tick();
    checkOutput("s5_noTimeout", 64'({reqA, reasonA}), 64'd0);
    checkOutput("s5_cnt1000", 64'(cntA), 64'd1000);
    stopA = 4'b0001;
    tick();
    stopA = 4'b0000;
    pulseAck();
    waitFinish("s5", 10);
    resetPulse("s5_rst");

    $display("[TB] 8-bit counter saturation");
    startB   = 1'b1;
    timeoutB = 8'd0;
    tick();
    startB = 1'b0;
    repeat (300) tick();
    checkOutput("s5_satCnt", 64'(cntB), 64'd255);
    checkOutput("s5_satRun", 64'({reqB, finishB, reasonB}), 64'd0);
    resetPulse("s5b_rst");
    checkOutput("s5_satRst", 64'(cntB), 64'd0);

    $display("[TB] idle ignores stops, reset aborts drain and run");
    stopA = 4'b1111;
    ackA  = 1'b1;
    repeat (3) tick();
    checkOutput("s6_idleIgnore", 64'({reqA, finishA, reasonA, ackTmoA, cntA}), 64'd0);
    stopA = 4'b0000;
    ackA  = 1'b0;
    applyStimulus(32'd10, none, 1'b0);
    repeat (13) tick();
    checkOutput("s6_inDrain", 64'(reqA), 64'd1);
    #2;
    resetPulse("s6_rstDrain");
    applyStimulus(32'd0, none, 1'b0);
    repeat (20) tick();
    checkOutput("s6_inRun", 64'(cntA), 64'd20);
    #2;
    resetPulse("s6_rstRun");
    checkOutput("s6_noFinish", 64'(finishA), 64'd0);
    applyStimulus(32'd30, '{REASON_TIMEOUT, 2'd0, 1'b0, 32'd30}, 1'b1);
    repeat (30) tick();
    checkOutput("s6_reqAfter", 64'(reqA), 64'd1);
    pulseAck();
    waitFinish("s6", 10);

    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
